// File: rtl/dmem_responder.sv
// Single-port data-memory responder: captures one request, optional wait states,
// one array access (read-before-write), then a one-cycle response strobe.
module dmem_responder #(
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req_rd,
   input  logic [3:0]  req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        busy,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AW        = $clog2(DEPTH);
   localparam logic [3:0]  WaitInit  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
   localparam logic [33:0] AddrLimit = 34'(DEPTH) << 2;

   typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} state_e;

   state_e        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          rd_q;
   logic [3:0]    we_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   rdata_q;
   logic          err_q;
   logic          capture;
   logic          req_present;
   logic          out_of_range;
   logic [AW-1:0] idx;

   // Backing store is deliberately left uninitialised.
   logic [31:0]   mem [DEPTH];

   assign req_present  = req_rd | (|req_we);
   assign out_of_range = {2'b00, addr_q} >= AddrLimit;
   assign idx          = addr_q[AW+1:2];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_present) begin
               capture = 1'b1;
               if (WAIT_CYCLES > 0) begin
                  state_d = StWait;
                  cnt_d   = WaitInit;
               end else begin
                  state_d = StAccess;
               end
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) state_d = StAccess;
            else               cnt_d   = cnt_q - 4'd1;
         end
         StAccess: state_d = StResp;
         StResp:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         rd_q    <= 1'b0;
         we_q    <= 4'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (capture) begin
            rd_q    <= req_rd;
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         // Error flag lives only for the RESP cycle that follows ACCESS.
         if (state_q == StAccess) begin
            rdata_q <= (rd_q && !out_of_range) ? mem[idx] : 32'd0;
            err_q   <= out_of_range;
         end else begin
            err_q   <= 1'b0;
         end
      end
   end

   // Reset forces state to IDLE asynchronously, so an aborted request never writes.
   always_ff @(posedge clk) begin
      if (state_q == StAccess && !out_of_range) begin
         for (int i = 0; i < 4; i++) begin
            if (we_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

   assign busy      = (state_q != StIdle);
   assign rsp_valid = (state_q == StResp);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter: DEPTH, 1024, number of 32-bit words in the backing array (power of two).
REQ-002 Parameter: WAIT_CYCLES, 0, wait states inserted before each array access (0..15).
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rstn  input  1  reset, asynchronous, active-low.
REQ-005 Port: req_rd  input  1  read request; may be a single-cycle pulse.
REQ-006 Port: req_we  input  4  byte-lane write enables; lane i writes bits [8i+7:8i].
REQ-007 Port: req_addr  input  32  byte address; word index = req_addr[log2(DEPTH)+1:2].
REQ-008 Port: req_wdata  input  32  write data, already lane-aligned.
REQ-009 Port: busy  output  1  high whenever state is not IDLE.
REQ-010 Port: rsp_valid  output  1  one-cycle response strobe.
REQ-011 Port: rsp_rdata  output  32  registered read data.
REQ-012 Port: rsp_err  output  1  address-range error flag, valid with rsp_valid.

Function
REQ-013 The block SHALL implement states IDLE, WAIT, ACCESS and RESP.
REQ-014 The block SHALL treat a request as present in IDLE when req_rd=1 or req_we!=0.
REQ-015 On a rising edge in IDLE with a request present, the block SHALL capture req_rd, req_we, req_addr and req_wdata into internal registers.
REQ-016 On that same edge, the block SHALL enter WAIT with the counter set to WAIT_CYCLES-1 when WAIT_CYCLES>0; otherwise it SHALL enter ACCESS.
REQ-017 In WAIT, the block SHALL decrement the counter each cycle and move to ACCESS on the edge where the counter is 0.
REQ-018 In ACCESS, the block SHALL write each enabled byte lane of the captured data into the addressed word at the end of the cycle.
REQ-019 In ACCESS, the block SHALL load the addressed word into rsp_rdata at the end of the cycle.
REQ-020 The ACCESS read SHALL be read-before-write: when read and write enables are both set, rsp_rdata SHALL return the pre-write contents.
REQ-021 When captured req_rd=0, the block SHALL set rsp_rdata to 32'h0 in ACCESS.
REQ-022 The block SHALL flag an address as out of range when captured req_addr >= 4*DEPTH.
REQ-023 For an out-of-range address, the block SHALL write no lane, SHALL load rsp_rdata with 32'h0 and SHALL set rsp_err=1 for the response.
REQ-024 The block SHALL ignore req_addr[1:0] for indexing and SHALL NOT flag a non-zero req_addr[1:0] as an error.
REQ-025 In RESP, the block SHALL drive rsp_valid=1 for exactly one cycle and SHALL then return to IDLE.
REQ-026 Latency: rsp_valid SHALL be high in the cycle beginning WAIT_CYCLES+2 edges after the capture edge.
REQ-027 The block SHALL ignore, and SHALL NOT queue, any request presented while busy=1, including during RESP.
REQ-028 A request may be accepted on the edge that leaves RESP only if it is still present in the following IDLE cycle.
REQ-029 rsp_err SHALL be 0 whenever rsp_valid=0.
REQ-030 rsp_rdata SHALL hold its value until the next ACCESS.
REQ-031 The block SHALL NOT initialise the backing array; contents SHALL be undefined until written.

Reset
REQ-032 While rstn=0, state SHALL be IDLE and busy, rsp_valid, rsp_err, rsp_rdata and the counter SHALL be 0.
REQ-033 A reset asserted in IDLE or WAIT SHALL abort the captured request; the array SHALL NOT be modified.
REQ-034 A reset asserted in ACCESS before its closing edge SHALL likewise leave the array unmodified.
REQ-035 After rstn deasserts, the first request SHALL be accepted no earlier than the first rising edge with rstn=1.

Verification
REQ-036 WAIT_CYCLES=0: write addr 0x10, we=4'hF, data 0xDEADBEEF, then read 0x10 -> rsp_valid 2 cycles after each capture, rdata 0xDEADBEEF, err 0.
REQ-037 Byte lanes: preload 0x11223344 at 0x20, write we=4'b0100 data 0x00AA0000, then read -> rdata 0x11AA3344.
REQ-038 WAIT_CYCLES=3: single-cycle req_rd pulse -> busy high for 5 cycles, rsp_valid in the 5th cycle after capture.
REQ-039 DEPTH=1024: write 0x1000 (out of range), then read 0x1000 -> both responses err=1, rdata 0; word 0 unchanged.
REQ-040 Request while busy: second pulse during WAIT -> ignored, exactly one rsp_valid.
REQ-041 Reset during WAIT of a write to 0x30 holding 0x5 -> outputs 0 and a later read of 0x30 returns 0x5.
